// File: rtl/pipe_barrier_elastic_if.sv
// Valid/ready/data handshake bundle for one side of a pipeline barrier.
// The producer side uses the master modport, the consumer side the slave modport.
interface pipe_barrier_elastic_if #(
  parameter int DATA_W = 96
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_barrier_elastic.sv
// Elastic pipeline barrier between two stages with valid/ready on both sides.
// SKID=1 holds up to two entries (main + skid) so upstream ready comes from a
// register; SKID=0 is a single register with combinational upstream ready.
// flush squashes every held entry; reset also clears the data registers.
// Optional macro PIPE_BARRIER_PERF_EN adds a saturating 16-bit stall counter
// (o_stall_cnt) counting cycles where the output is held by backpressure.
module pipe_barrier_elastic #(
  parameter int DATA_W = 96,
  parameter int SKID   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  pipe_barrier_elastic_if.slave  i_up,
  pipe_barrier_elastic_if.master o_dn,
  output logic [1:0]            o_occupancy
`ifdef PIPE_BARRIER_PERF_EN
  ,
  output logic [15:0]           o_stall_cnt
`endif
);

  logic              r_mainValid;
  logic [DATA_W-1:0] r_mainData;
  logic              r_skidValid;
  logic [DATA_W-1:0] r_skidData;
  logic [1:0]        r_occ;

  logic              w_inReady;
  logic              w_accept;
  logic              w_drain;
  logic              w_nextMainValid;
  logic [DATA_W-1:0] w_nextMainData;
  logic              w_nextSkidValid;
  logic [DATA_W-1:0] w_nextSkidData;
  logic [1:0]        w_nextOcc;

  // Upstream ready and the two handshake events for this cycle.
  always_comb begin
    w_inReady = 1'b1;
    if (SKID != 0) begin
      w_inReady = ~r_skidValid;
    end else begin
      w_inReady = ~r_mainValid | o_dn.ready;
    end
    w_accept = i_up.valid & w_inReady;
    w_drain  = r_mainValid & o_dn.ready;
  end

  // Next contents of main/skid; flush drops valids but leaves data alone.
  always_comb begin
    w_nextMainValid = r_mainValid;
    w_nextMainData  = r_mainData;
    w_nextSkidValid = r_skidValid;
    w_nextSkidData  = r_skidData;
    if (i_flush) begin
      w_nextMainValid = 1'b0;
      w_nextSkidValid = 1'b0;
    end else if (SKID != 0) begin
      if (w_drain) begin
        if (r_skidValid) begin
          w_nextMainValid = 1'b1;
          w_nextMainData  = r_skidData;
          w_nextSkidValid = 1'b0;
        end else begin
          w_nextMainValid = 1'b0;
        end
      end
      if (w_accept) begin
        if (~r_mainValid | w_drain) begin
          w_nextMainValid = 1'b1;
          w_nextMainData  = i_up.data;
        end else begin
          w_nextSkidValid = 1'b1;
          w_nextSkidData  = i_up.data;
        end
      end
    end else begin
      if (w_accept) begin
        w_nextMainValid = 1'b1;
        w_nextMainData  = i_up.data;
      end else if (w_drain) begin
        w_nextMainValid = 1'b0;
      end
    end
    w_nextOcc = {1'b0, w_nextMainValid} + {1'b0, w_nextSkidValid};
  end

  // Entry registers and occupancy; reset wipes everything including data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mainValid <= 1'b0;
      r_mainData  <= '0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
      r_occ       <= 2'd0;
    end else begin
      r_mainValid <= w_nextMainValid;
      r_mainData  <= w_nextMainData;
      r_skidValid <= w_nextSkidValid;
      r_skidData  <= w_nextSkidData;
      r_occ       <= w_nextOcc;
    end
  end

  assign i_up.ready  = w_inReady;
  assign o_dn.valid  = r_mainValid;
  assign o_dn.data   = r_mainData;
  assign o_occupancy = r_occ;

`ifdef PIPE_BARRIER_PERF_EN
  logic [15:0] r_stallCnt;

  // Count backpressure cycles, saturating; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCnt <= 16'd0;
    end else if (r_mainValid & ~o_dn.ready & (r_stallCnt != 16'hFFFF)) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign o_stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_pipe_barrier_elastic.sv
// Table-driven bench for pipe_barrier_elastic: one SKID=1 and one SKID=0
// instance, both 16 bits wide, driven by a vector table plus hand sequences.
module tb_pipe_barrier_elastic;

  typedef struct {
    bit          sel;
    bit          rst;
    bit          fl;
    bit          iv;
    logic [15:0] id;
    bit          ordy;
    bit          eov;
    logic [15:0] eod;
    bit          eir;
    logic [1:0]  eocc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetA, resetB;
  logic       flushA, flushB;
  logic [1:0] occA, occB;
`ifdef PIPE_BARRIER_PERF_EN
  logic [15:0] stallA, stallB;
`endif

  pipe_barrier_elastic_if #(.DATA_W(16)) inA ();
  pipe_barrier_elastic_if #(.DATA_W(16)) outA ();
  pipe_barrier_elastic_if #(.DATA_W(16)) inB ();
  pipe_barrier_elastic_if #(.DATA_W(16)) outB ();

  pipe_barrier_elastic #(.DATA_W(16), .SKID(1)) dutSkid (
    .clk         (clk),
    .reset       (resetA),
    .i_flush     (flushA),
    .i_up        (inA),
    .o_dn        (outA),
    .o_occupancy (occA)
`ifdef PIPE_BARRIER_PERF_EN
    ,
    .o_stall_cnt (stallA)
`endif
  );

  pipe_barrier_elastic #(.DATA_W(16), .SKID(0)) dutNoSkid (
    .clk         (clk),
    .reset       (resetB),
    .i_flush     (flushB),
    .i_up        (inB),
    .o_dn        (outB),
    .o_occupancy (occB)
`ifdef PIPE_BARRIER_PERF_EN
    ,
    .o_stall_cnt (stallB)
`endif
  );

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic addV(input bit sel, input bit rst, input bit fl, input bit iv,
                      input logic [15:0] id, input bit ordy, input bit eov,
                      input logic [15:0] eod, input bit eir, input logic [1:0] eocc);
    vec_t v;
    v.sel = sel; v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.eov = eov; v.eod = eod; v.eir = eir; v.eocc = eocc;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // Drive the selected instance, idle the other (its reset is left alone),
  // then sample one time unit after the rising edge.
  task automatic applyStimulus(input vec_t v);
    if (v.sel) begin
      resetA = v.rst; flushA = v.fl; inA.valid = v.iv; inA.data = v.id; outA.ready = v.ordy;
      flushB = 1'b0; inB.valid = 1'b0; outB.ready = 1'b0;
    end else begin
      resetB = v.rst; flushB = v.fl; inB.valid = v.iv; inB.data = v.id; outB.ready = v.ordy;
      flushA = 1'b0; inA.valid = 1'b0; outA.ready = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetA = 1'b1; resetB = 1'b1; flushA = 1'b0; flushB = 1'b0;
    inA.valid = 1'b0; inA.data = '0; outA.ready = 1'b0;
    inB.valid = 1'b0; inB.data = '0; outB.ready = 1'b0;

    // SKID=1: reset release, streaming, backpressure, flush, mid-transfer reset
    addV(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2'd0);
    for (int k = 1; k <= 8; k++) addV(1, 0, 0, 1, 16'(k), 1, 1, 16'(k), 1, 2'd1);
    addV(1, 0, 0, 0, 16'h0000, 1, 0, 16'h0008, 1, 2'd0);
    addV(1, 0, 0, 1, 16'hAAAA, 0, 1, 16'hAAAA, 1, 2'd1);
    addV(1, 0, 0, 1, 16'hBBBB, 0, 1, 16'hAAAA, 0, 2'd2);
    addV(1, 0, 0, 1, 16'hCCCC, 0, 1, 16'hAAAA, 0, 2'd2);
    addV(1, 0, 0, 0, 16'h0000, 1, 1, 16'hBBBB, 1, 2'd1);
    addV(1, 0, 0, 0, 16'h0000, 1, 0, 16'hBBBB, 1, 2'd0);
    addV(1, 0, 0, 1, 16'h1111, 0, 1, 16'h1111, 1, 2'd1);
    addV(1, 0, 0, 1, 16'h2222, 0, 1, 16'h1111, 0, 2'd2);
    addV(1, 0, 1, 1, 16'h00E0, 0, 0, 16'h1111, 1, 2'd0);
    addV(1, 0, 0, 0, 16'h0000, 1, 0, 16'h1111, 1, 2'd0);
    addV(1, 0, 0, 1, 16'h3333, 0, 1, 16'h3333, 1, 2'd1);
    addV(1, 0, 1, 1, 16'h00E0, 0, 0, 16'h3333, 1, 2'd0);
    addV(1, 0, 0, 0, 16'h0000, 1, 0, 16'h3333, 1, 2'd0);
    addV(1, 0, 0, 1, 16'h4444, 0, 1, 16'h4444, 1, 2'd1);
    addV(1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2'd0);
    addV(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2'd0);
    // SKID=0: reset release, hold, simultaneous accept/drain, flush discard
    addV(0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2'd0);
    addV(0, 0, 0, 1, 16'h00C0, 0, 1, 16'h00C0, 0, 2'd1);
    addV(0, 0, 0, 0, 16'h0000, 0, 1, 16'h00C0, 0, 2'd1);
    addV(0, 0, 0, 1, 16'h00D0, 1, 1, 16'h00D0, 1, 2'd1);
    addV(0, 0, 0, 0, 16'h0000, 1, 0, 16'h00D0, 1, 2'd0);
    addV(0, 0, 0, 1, 16'h00F0, 0, 1, 16'h00F0, 0, 2'd1);
    addV(0, 0, 0, 1, 16'h0BAD, 0, 1, 16'h00F0, 0, 2'd1);
    addV(0, 0, 0, 0, 16'h0000, 1, 0, 16'h00F0, 1, 2'd0);
    addV(0, 0, 1, 1, 16'h0111, 0, 0, 16'h00F0, 1, 2'd0);
    addV(0, 0, 0, 0, 16'h0000, 0, 0, 16'h00F0, 1, 2'd0);

    $display("[TB] starting, %0d vectors", vecs.size());

    // Two cycles of reset on both instances; ready must be up during reset.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready_skid1", -1, 16'(inA.ready), 16'd1);
    checkOutput("rst_valid_skid1", -1, 16'(outA.valid), 16'd0);
    checkOutput("rst_ready_skid0", -1, 16'(inB.ready), 16'd1);
    checkOutput("rst_valid_skid0", -1, 16'(outB.valid), 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].sel) begin
        checkOutput("out_valid", i, 16'(outA.valid), 16'(vecs[i].eov));
        checkOutput("out_data",  i, outA.data,       vecs[i].eod);
        checkOutput("in_ready",  i, 16'(inA.ready),  16'(vecs[i].eir));
        checkOutput("occupancy", i, 16'(occA),       16'(vecs[i].eocc));
      end else begin
        checkOutput("out_valid", i, 16'(outB.valid), 16'(vecs[i].eov));
        checkOutput("out_data",  i, outB.data,       vecs[i].eod);
        checkOutput("in_ready",  i, 16'(inB.ready),  16'(vecs[i].eir));
        checkOutput("occupancy", i, 16'(occB),       16'(vecs[i].eocc));
      end
    end

`ifdef PIPE_BARRIER_PERF_EN
    begin
      vec_t v;
      v = '{sel:1, rst:1, fl:0, iv:0, id:16'h0, ordy:0, eov:0, eod:16'h0, eir:1, eocc:2'd0};
      applyStimulus(v);
      checkOutput("stall_after_reset", -1, stallA, 16'd0);
      v.rst = 0; v.iv = 1; v.id = 16'h5555;
      applyStimulus(v);
      v.iv = 0;
      for (int c = 0; c < 10; c++) applyStimulus(v);
      checkOutput("stall_ten", -1, stallA, 16'd10);
      v.fl = 1; v.ordy = 1;
      applyStimulus(v);
      checkOutput("stall_after_flush", -1, stallA, 16'd10);
      v.fl = 0; v.ordy = 0; v.rst = 1;
      applyStimulus(v);
      checkOutput("stall_cleared", -1, stallA, 16'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
